// File: rtl/dp_ram_ctrl.sv
// Dual-port byte-enabled RAM. Port A wins byte-wise write collisions.
// A reset-driven sequencer optionally zero-fills the array before requests are accepted.
module dp_ram_ctrl #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int OUT_REG    = 0,
   parameter int RDW_MODE   = 0,
   parameter int ZERO_INIT  = 1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    en_a_i,
   input  logic [ADDR_WIDTH-1:0]   addr_a_i,
   input  logic                    we_a_i,
   input  logic [DATA_WIDTH/8-1:0] be_a_i,
   input  logic [DATA_WIDTH-1:0]   wdata_a_i,
   output logic [DATA_WIDTH-1:0]   rdata_a_o,
   output logic                    rvalid_a_o,
   input  logic                    en_b_i,
   input  logic [ADDR_WIDTH-1:0]   addr_b_i,
   input  logic                    we_b_i,
   input  logic [DATA_WIDTH/8-1:0] be_b_i,
   input  logic [DATA_WIDTH-1:0]   wdata_b_i,
   output logic [DATA_WIDTH-1:0]   rdata_b_o,
   output logic                    rvalid_b_o,
   output logic                    init_done_o,
   output logic                    collision_o
);
   localparam int BE_WIDTH = DATA_WIDTH / 8;
   localparam int DEPTH    = 2 ** ADDR_WIDTH;

   typedef enum logic {ST_INIT, ST_READY} state_e;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
   logic                    fill_we;

   logic                    ready, same_addr;
   logic                    acc_a, acc_b, wr_a, wr_b, rd_a, rd_b;
   logic [BE_WIDTH-1:0]     wmask_a, wmask_b;
   logic [DATA_WIDTH-1:0]   rmerge_a, rmerge_b;

   logic                    collision_q, collision_d;
   logic                    rvalid1_a_q, rvalid1_a_d, rvalid1_b_q, rvalid1_b_d;
   logic [DATA_WIDTH-1:0]   rdata1_a_q, rdata1_a_d, rdata1_b_q, rdata1_b_d;

   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      fill_we = 1'b0;
      case (state_q)
         ST_INIT: begin
            if (ZERO_INIT != 0) begin
               fill_we = ~rst_i;
               cnt_d   = cnt_q + 1'b1;
               if (cnt_q == {ADDR_WIDTH{1'b1}}) state_d = ST_READY;
            end else begin
               state_d = ST_READY;
            end
         end
         default: ;
      endcase
   end

   // Requests in the reset cycle itself are dropped so nothing leaks past a reset.
   assign ready     = (state_q == ST_READY) & ~rst_i;
   assign same_addr = (addr_a_i == addr_b_i);
   assign acc_a     = en_a_i & ready;
   assign acc_b     = en_b_i & ready;
   assign wr_a      = acc_a & we_a_i;
   assign wr_b      = acc_b & we_b_i;
   assign rd_a      = acc_a & ~we_a_i;
   assign rd_b      = acc_b & ~we_b_i;

   // B loses every byte A also writes, so the two write masks never overlap.
   always_comb begin
      wmask_a = wr_a ? be_a_i : '0;
      wmask_b = wr_b ? be_b_i : '0;
      if (wr_a && same_addr) wmask_b = wmask_b & ~be_a_i;
   end

   always_ff @(posedge clk_i) begin
      if (fill_we) mem_q[cnt_q] <= '0;
      for (int k = 0; k < BE_WIDTH; k++) begin
         if (wmask_a[k]) mem_q[addr_a_i][8*k +: 8] <= wdata_a_i[8*k +: 8];
         if (wmask_b[k]) mem_q[addr_b_i][8*k +: 8] <= wdata_b_i[8*k +: 8];
      end
   end

   // Only the other port can be writing when a port reads, so only its mask is overlaid.
   always_comb begin
      rmerge_a = mem_q[addr_a_i];
      rmerge_b = mem_q[addr_b_i];
      if (RDW_MODE != 0 && same_addr) begin
         for (int k = 0; k < BE_WIDTH; k++) begin
            if (wmask_b[k]) rmerge_a[8*k +: 8] = wdata_b_i[8*k +: 8];
            if (wmask_a[k]) rmerge_b[8*k +: 8] = wdata_a_i[8*k +: 8];
         end
      end
   end

   always_comb begin
      collision_d = acc_a & acc_b & same_addr & (we_a_i | we_b_i);
      rvalid1_a_d = rd_a;
      rvalid1_b_d = rd_b;
      rdata1_a_d  = rd_a ? rmerge_a : rdata1_a_q;
      rdata1_b_d  = rd_b ? rmerge_b : rdata1_b_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         collision_q <= 1'b0;
         rvalid1_a_q <= 1'b0;
         rvalid1_b_q <= 1'b0;
         rdata1_a_q  <= '0;
         rdata1_b_q  <= '0;
      end else begin
         collision_q <= collision_d;
         rvalid1_a_q <= rvalid1_a_d;
         rvalid1_b_q <= rvalid1_b_d;
         rdata1_a_q  <= rdata1_a_d;
         rdata1_b_q  <= rdata1_b_d;
      end
   end

   generate
      if (OUT_REG != 0) begin : g_oreg
         logic                  rvalid2_a_q, rvalid2_a_d, rvalid2_b_q, rvalid2_b_d;
         logic [DATA_WIDTH-1:0] rdata2_a_q, rdata2_a_d, rdata2_b_q, rdata2_b_d;

         always_comb begin
            rvalid2_a_d = rvalid1_a_q;
            rvalid2_b_d = rvalid1_b_q;
            rdata2_a_d  = rvalid1_a_q ? rdata1_a_q : rdata2_a_q;
            rdata2_b_d  = rvalid1_b_q ? rdata1_b_q : rdata2_b_q;
         end

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               rvalid2_a_q <= 1'b0;
               rvalid2_b_q <= 1'b0;
               rdata2_a_q  <= '0;
               rdata2_b_q  <= '0;
            end else begin
               rvalid2_a_q <= rvalid2_a_d;
               rvalid2_b_q <= rvalid2_b_d;
               rdata2_a_q  <= rdata2_a_d;
               rdata2_b_q  <= rdata2_b_d;
            end
         end

         assign rvalid_a_o = rvalid2_a_q;
         assign rvalid_b_o = rvalid2_b_q;
         assign rdata_a_o  = rdata2_a_q;
         assign rdata_b_o  = rdata2_b_q;
      end else begin : g_noreg
         assign rvalid_a_o = rvalid1_a_q;
         assign rvalid_b_o = rvalid1_b_q;
         assign rdata_a_o  = rdata1_a_q;
         assign rdata_b_o  = rdata1_b_q;
      end
   endgenerate

   assign init_done_o = (state_q == ST_READY);
   assign collision_o = collision_q;

endmodule

// File: tb/tb_dp_ram_ctrl.sv
// Directed bench: two instances share stimulus -- d0 is latency 1 / read-first,
// d1 is latency 2 / write-first -- so every test plan item sees both modes.
module tb_dp_ram_ctrl;
   localparam int AW = 4;
   localparam int DW = 32;
   localparam int BW = DW / 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          en_a, we_a, en_b, we_b;
   logic [AW-1:0] addr_a, addr_b;
   logic [BW-1:0] be_a, be_b;
   logic [DW-1:0] wd_a, wd_b;

   logic [1:0][DW-1:0] rd_a, rd_b;
   logic [1:0]         rv_a, rv_b, done, coll;

   int n_tests = 0;
   int n_fail  = 0;

   dp_ram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(0), .RDW_MODE(0), .ZERO_INIT(1)) u_d0 (
      .clk_i(clk), .rst_i(rst),
      .en_a_i(en_a), .addr_a_i(addr_a), .we_a_i(we_a), .be_a_i(be_a), .wdata_a_i(wd_a),
      .rdata_a_o(rd_a[0]), .rvalid_a_o(rv_a[0]),
      .en_b_i(en_b), .addr_b_i(addr_b), .we_b_i(we_b), .be_b_i(be_b), .wdata_b_i(wd_b),
      .rdata_b_o(rd_b[0]), .rvalid_b_o(rv_b[0]),
      .init_done_o(done[0]), .collision_o(coll[0]));

   dp_ram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(1), .RDW_MODE(1), .ZERO_INIT(1)) u_d1 (
      .clk_i(clk), .rst_i(rst),
      .en_a_i(en_a), .addr_a_i(addr_a), .we_a_i(we_a), .be_a_i(be_a), .wdata_a_i(wd_a),
      .rdata_a_o(rd_a[1]), .rvalid_a_o(rv_a[1]),
      .en_b_i(en_b), .addr_b_i(addr_b), .we_b_i(we_b), .be_b_i(be_b), .wdata_b_i(wd_b),
      .rdata_b_o(rd_b[1]), .rvalid_b_o(rv_b[1]),
      .init_done_o(done[1]), .collision_o(coll[1]));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      en_a = 1'b0; we_a = 1'b0; en_b = 1'b0; we_b = 1'b0;
   endtask

   task automatic wr_a(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
      en_a = 1'b1; we_a = 1'b1; addr_a = a; wd_a = d; be_a = be;
   endtask

   task automatic rdq_a(input logic [AW-1:0] a);
      en_a = 1'b1; we_a = 1'b0; addr_a = a;
   endtask

   logic [DW-1:0] exp_w;
   logic [1:0]    rv_seen;

   initial begin
      rst = 1'b1; idle();
      addr_a = '0; addr_b = '0; be_a = '0; be_b = '0; wd_a = '0; wd_b = '0;
      step(); step();

      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst rv_a d%0d", d), rv_a[d], 0);
         chk($sformatf("rst rv_b d%0d", d), rv_b[d], 0);
         chk($sformatf("rst rd_a d%0d", d), rd_a[d], 0);
         chk($sformatf("rst rd_b d%0d", d), rd_b[d], 0);
         chk($sformatf("rst coll d%0d", d), coll[d], 0);
         chk($sformatf("rst done d%0d", d), done[d], 0);
      end

      // Fill timing; a read held during INIT must never produce rvalid.
      rst = 1'b0; rdq_a(4'd0); rv_seen = '0;
      for (int i = 1; i <= 16; i++) begin
         step();
         rv_seen |= rv_a;
         if (i == 15) chk("fill done@15", done, 2'b00);
         if (i == 16) chk("fill done@16", done, 2'b11);
      end
      idle();
      chk("init rv drop", rv_seen, 2'b00);

      // Back-to-back zero reads on both ports, same address (no collision).
      for (int i = 0; i < 18; i++) begin
         en_a = (i < 16); en_b = (i < 16); addr_a = 4'(i); addr_b = 4'(i);
         step();
         chk($sformatf("zs%0d rv_a d0", i), rv_a[0], (i < 16));
         chk($sformatf("zs%0d rv_b d0", i), rv_b[0], (i < 16));
         chk($sformatf("zs%0d rv_a d1", i), rv_a[1], (i >= 1 && i <= 16));
         chk($sformatf("zs%0d rv_b d1", i), rv_b[1], (i >= 1 && i <= 16));
         chk($sformatf("zs%0d data", i), {rd_a[0] | rd_a[1] | rd_b[0] | rd_b[1]}, 0);
         chk($sformatf("zs%0d coll", i), coll, 2'b00);
      end
      idle();

      // Partial byte-enable write then read-back.
      wr_a(4'd3, 32'hDEADBEEF, 4'b0101); step();
      chk("be0101 coll", coll, 2'b00);
      rdq_a(4'd3); step();
      chk("be0101 rv d0", rv_a[0], 1);
      chk("be0101 rd d0", rd_a[0], 32'h00AD00EF);
      chk("be0101 rv d1 early", rv_a[1], 0);
      idle(); step();
      chk("be0101 rv d1", rv_a[1], 1);
      chk("be0101 rd d1", rd_a[1], 32'h00AD00EF);
      chk("be0101 rv d0 after", rv_a[0], 0);

      // be=0 write is a no-op.
      wr_a(4'd3, 32'hFFFFFFFF, 4'b0000); step();
      rdq_a(4'd3); step();
      chk("be0 rd d0", rd_a[0], 32'h00AD00EF);
      idle(); step();
      chk("be0 rd d1", rd_a[1], 32'h00AD00EF);

      // Write-write collision at addr 5.
      wr_a(4'd5, 32'h11111111, 4'b0011);
      en_b = 1'b1; we_b = 1'b1; addr_b = 4'd5; wd_b = 32'h22222222; be_b = 4'b0110;
      step();
      chk("ww coll", coll, 2'b11);
      idle(); rdq_a(4'd5); step();
      chk("ww coll pulse", coll, 2'b00);
      chk("ww rd d0", rd_a[0], 32'h00221111);
      idle(); step();
      chk("ww rd d1", rd_a[1], 32'h00221111);

      // Cross-port read during write at addr 7.
      wr_a(4'd7, 32'hAAAAAAAA, 4'b1111); step();
      wr_a(4'd7, 32'h55555555, 4'b1111);
      en_b = 1'b1; we_b = 1'b0; addr_b = 4'd7;
      step();
      chk("rdw rv_b d0", rv_b[0], 1);
      chk("rdw rd_b d0", rd_b[0], 32'hAAAAAAAA);
      chk("rdw coll", coll, 2'b11);
      idle(); step();
      chk("rdw rv_b d1", rv_b[1], 1);
      chk("rdw rd_b d1", rd_b[1], 32'h55555555);
      chk("rdw coll pulse", coll, 2'b00);
      rdq_a(4'd7); step();
      chk("rdw next d0", rd_a[0], 32'h55555555);
      idle(); step();
      chk("rdw next d1", rd_a[1], 32'h55555555);

      // Distinct data everywhere, then in-order back-to-back reads on both ports.
      for (int i = 0; i < 16; i++) begin
         wr_a(4'(i), 32'h01010101 * i, 4'b1111); step();
      end
      idle();
      for (int i = 0; i < 18; i++) begin
         en_a = (i < 16); en_b = (i < 16); we_a = 1'b0; we_b = 1'b0;
         addr_a = 4'(i); addr_b = 4'(i);
         step();
         if (i < 16) begin
            exp_w = 32'h01010101 * i;
            chk($sformatf("ord%0d rv d0", i), {rv_a[0], rv_b[0]}, 2'b11);
            chk($sformatf("ord%0d rd_a d0", i), rd_a[0], exp_w);
            chk($sformatf("ord%0d rd_b d0", i), rd_b[0], exp_w);
         end
         if (i >= 1 && i <= 16) begin
            exp_w = 32'h01010101 * (i - 1);
            chk($sformatf("ord%0d rv d1", i), {rv_a[1], rv_b[1]}, 2'b11);
            chk($sformatf("ord%0d rd_a d1", i), rd_a[1], exp_w);
            chk($sformatf("ord%0d rd_b d1", i), rd_b[1], exp_w);
         end else begin
            chk($sformatf("ord%0d no rv d1", i), {rv_a[1], rv_b[1]}, 2'b00);
         end
      end
      idle();

      // Reset flushes an in-flight read, then a mid-fill reset restarts the fill.
      rdq_a(4'd2); step();
      chk("flush rd d0", rd_a[0], 32'h02020202);
      chk("flush rv d1 early", rv_a[1], 0);
      idle(); rst = 1'b1; step();
      chk("flush rv d1", rv_a[1], 0);
      chk("flush rd d1", rd_a[1], 0);
      chk("flush done", done, 2'b00);
      rst = 1'b0;
      for (int i = 0; i < 9; i++) step();
      chk("mid done", done, 2'b00);
      rst = 1'b1; step(); rst = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         step();
         if (i == 15) chk("refill done@15", done, 2'b00);
         if (i == 16) chk("refill done@16", done, 2'b11);
      end
      rdq_a(4'd2); step();
      chk("refill rd d0", {rv_a[0], rd_a[0]}, {1'b1, 32'h0});
      idle(); step();
      chk("refill rd d1", {rv_a[1], rd_a[1]}, {1'b1, 32'h0});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dp_ram_ctrl.md
# dp_ram_ctrl

Parametrised dual-port RAM that generalises the 32-bit byte-enabled dual-port memory. It adds configurable data width, a selectable read latency, a selectable read-during-write mode, deterministic write-collision arbitration, and a reset-driven zero-initialisation sequencer. It serves as core-local instruction/data memory and scratchpad. Ports A and B are symmetric except that port A has write priority.

## Interface
- ADDR_WIDTH, 8, word address width; depth = 2**ADDR_WIDTH
- DATA_WIDTH, 32, word width; must be a multiple of 8; BE_WIDTH = DATA_WIDTH/8
- OUT_REG, 0, 0: read latency 1; 1: extra output register, read latency 2
- RDW_MODE, 0, 0: read-first (old data); 1: write-first (new data merged per byte)
- ZERO_INIT, 1, 1: zero-fill whole array after reset; 0: no fill

Ports:
- clk_i  in  1  single clock, all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- en_a_i  in  1  port A access request
- addr_a_i  in  ADDR_WIDTH  port A word address
- we_a_i  in  1  port A write (1) / read (0)
- be_a_i  in  BE_WIDTH  port A byte enables, bit k covers wdata[8k+7:8k]
- wdata_a_i  in  DATA_WIDTH  port A write data
- rdata_a_o  out  DATA_WIDTH  port A read data
- rvalid_a_o  out  1  port A read data valid, one-cycle pulse per read
- en_b_i, addr_b_i, we_b_i, be_b_i, wdata_b_i, rdata_b_o, rvalid_b_o: same as port A, for port B
- init_done_o  out  1  array ready; requests are ignored while 0
- collision_o  out  1  one-cycle pulse: both ports enabled on the same address with at least one writing

## Operation
- FSM states: INIT and READY. rst_i forces INIT and clears the fill counter to 0.
- INIT with ZERO_INIT=1: writes all-zero to word[cnt] each cycle and increments cnt. After writing word 2**ADDR_WIDTH-1 the FSM moves to READY. Total fill time is 2**ADDR_WIDTH cycles.
- INIT with ZERO_INIT=0: moves to READY on the first cycle after reset deasserts. Array contents are undefined.
- init_done_o = (state == READY), registered.
- While not READY, all port requests are dropped: no write, no rvalid, no collision.
- Accepted access: en_x_i=1 in READY.
  - Write: updates only the bytes selected by be_x_i. A write with be=0 changes nothing.
  - Read (we=0): returns the full word.
- Write collision (both ports write the same address):
  - Each byte is taken from A if be_a[k]=1, otherwise from B if be_b[k]=1.
  - B's non-overlapping bytes are always committed.
- Read data source:
  - RDW_MODE=0: the array contents before this cycle's writes, for same-port and cross-port reads.
  - RDW_MODE=1: the old word overlaid per byte with this cycle's effective writes to that address, A priority applied.
- A read on a port that is also writing cannot happen, since we selects one operation. Same-port RDW applies only to the cross-port case and to back-to-back cycles. A read in the cycle after a write always sees the new data.
- collision_o is registered: it pulses the cycle after the colliding request. Two reads to the same address do not flag a collision.
- rdata_x_o holds its last value until the next read completes.

## Timing
- Reset values: rdata_a_o=rdata_b_o=0, rvalid_a_o=rvalid_b_o=0, collision_o=0, init_done_o=0.
- Read latency: request at cycle N gives rdata/rvalid at N+1 with OUT_REG=0, or N+2 with OUT_REG=1.
- Throughput: one access per port per cycle, fully pipelined, no back-pressure.
- With OUT_REG=1, the output stage clears rvalid on cycles with no read in the pipeline.
- rst_i asserted mid-fill restarts the fill at word 0. rst_i asserted in READY re-runs the fill when ZERO_INIT=1.
- Reset also flushes in-flight reads: their rvalid never asserts.
- First accepted request: the cycle in which init_done_o=1 is first observed.

## Test plan
- Reset, ZERO_INIT=1, ADDR_WIDTH=4 -> init_done_o rises exactly 16 cycles after rst_i deasserts. Every address then reads 0x00000000. A request issued during INIT produces no rvalid.
- Port A writes 0xDEADBEEF with be=4'b0101 at addr 3, then reads addr 3 -> 0x00AD00EF, with rvalid 1 cycle later (OUT_REG=0) or 2 cycles later (OUT_REG=1).
- Same cycle, addr 5: A writes 0x11111111 with be=0011 and B writes 0x22222222 with be=0110 -> word = 0x00221111; collision_o pulses once the next cycle.
- Addr 7 holds 0xAAAAAAAA; A writes 0x55555555 (be=1111) while B reads addr 7 -> B sees 0xAAAAAAAA with RDW_MODE=0, 0x55555555 with RDW_MODE=1. collision_o=1.
- Back-to-back reads on both ports at addrs 0..15 with OUT_REG=1 -> 16 consecutive rvalid pulses per port, in address order, with no gaps.
- rst_i pulsed at fill count 9 -> fill restarts; init_done_o rises 16 cycles after the second release. An in-flight read is dropped.
